// File: rtl/car_sequencer.sv
// Control-address sequencer: steps the CAR through fetch, addressing-mode and
// interrupt micro-sequences, stalling whenever the datapath is not ready.
`ifndef CAR_SEQUENCER_CODES
`define CAR_SEQUENCER_CODES
`define CAR_0          0
`define CAR_REG_REG    1
`define CAR_REG_IDX0   2
`define CAR_REG_IDX1   3
`define CAR_REG_IDX2   4
`define CAR_REG_IDX3   5
`define CAR_IND_REG0   6
`define CAR_IND_REG1   7
`define CAR_IND_IDX0   8
`define CAR_IND_IDX1   9
`define CAR_IND_IDX2   10
`define CAR_IND_IDX3   11
`define CAR_IND_IDX4   12
`define CAR_IDX_REG0   13
`define CAR_IDX_REG1   14
`define CAR_IDX_REG2   15
`define CAR_IDX_IDX0   16
`define CAR_IDX_IDX1   17
`define CAR_IDX_IDX2   18
`define CAR_IDX_IDX3   19
`define CAR_IDX_IDX4   20
`define CAR_IDX_IDX5   21
`define CAR_1OP_REG    22
`define CAR_1OP_IND0   23
`define CAR_1OP_IND1   24
`define CAR_1OP_IND2   25
`define CAR_1OP_IDX0   26
`define CAR_1OP_IDX1   27
`define CAR_1OP_IDX2   28
`define CAR_1OP_IDX3   29
`define CAR_PUSH_REG0  30
`define CAR_PUSH_REG1  31
`define CAR_PUSH_REG2  32
`define CAR_PUSH_IND0  33
`define CAR_PUSH_IND1  34
`define CAR_PUSH_IND2  35
`define CAR_PUSH_IDX0  36
`define CAR_PUSH_IDX1  37
`define CAR_PUSH_IDX2  38
`define CAR_PUSH_IDX3  39
`define CAR_CALL_REG0  40
`define CAR_CALL_REG1  41
`define CAR_CALL_REG2  42
`define CAR_CALL_IND0  43
`define CAR_CALL_IND1  44
`define CAR_CALL_IND2  45
`define CAR_CALL_IDX0  46
`define CAR_CALL_IDX1  47
`define CAR_CALL_IDX2  48
`define CAR_CALL_IDX3  49
`define CAR_RETI0      50
`define CAR_RETI1      51
`define CAR_RETI2      52
`define CAR_RETI3      53
`define CAR_JMP0       54
`define CAR_INT0       55
`define CAR_INT1       56
`define CAR_INT2       57
`define CAR_INT3       58
`define CAR_INT4       59
`define CAR_NUM_STATES 60
`endif

module car_sequencer #(
    parameter int unsigned CAR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         IW_next,
    input  logic                ready,
    input  logic                int_req,
    input  logic                gie,
    output logic [CAR_BITS-1:0] CAR,
    output logic                int_ack,
    output logic                illegal
);

    localparam logic [CAR_BITS-1:0] S_FETCH = CAR_BITS'(`CAR_0);
    localparam logic [CAR_BITS-1:0] S_JMP0  = CAR_BITS'(`CAR_JMP0);
    localparam logic [CAR_BITS-1:0] S_RETI0 = CAR_BITS'(`CAR_RETI0);
    localparam logic [CAR_BITS-1:0] S_INT0  = CAR_BITS'(`CAR_INT0);
    localparam logic [CAR_BITS-1:0] S_INT4  = CAR_BITS'(`CAR_INT4);
    localparam logic [CAR_BITS-1:0] S_LIMIT = CAR_BITS'(`CAR_NUM_STATES);

    logic [CAR_BITS-1:0] car_q, car_d;
    logic                int_ack_q, int_ack_d;
    logic                illegal_q, illegal_d;
    logic                fmt1, fmt2, jmp, cg, ad;
    logic [3:0]          src;
    logic [1:0]          as_raw, as_eff;
    logic [CAR_BITS-1:0] dec_state;
    logic                dec_illegal;
    logic                is_term;
    logic                unused_iw;

    // Pick the register / indirect / indexed flavour of an entry point from As.
    function automatic logic [CAR_BITS-1:0] by_as(input logic [1:0] a, input int unsigned r,
                                                  input int unsigned i, input int unsigned x);
        logic [CAR_BITS-1:0] s;
        if (a == 2'b00)  s = CAR_BITS'(r);
        else if (a[1])   s = CAR_BITS'(i);
        else             s = CAR_BITS'(x);
        return s;
    endfunction

    assign fmt1      = IW_next[15:12] >= 4'd4;
    assign fmt2      = IW_next[15:10] == 6'b000100;
    assign jmp       = IW_next[15:13] == 3'b001;
    assign src       = IW_next[11:8];
    assign as_raw    = IW_next[5:4];
    assign ad        = IW_next[7];
    assign unused_iw = ^{IW_next[6], IW_next[3:0]};

    // R3 and R2-indirect sources are constants, so they need no operand fetch.
    assign cg     = (src == 4'd3) || ((src == 4'd2) && as_raw[1]);
    assign as_eff = cg ? 2'b00 : as_raw;

    always_comb begin
        dec_state   = S_FETCH;
        dec_illegal = 1'b0;
        if (fmt1) begin
            if (ad) dec_state = by_as(as_eff, `CAR_REG_IDX0, `CAR_IND_IDX0, `CAR_IDX_IDX0);
            else    dec_state = by_as(as_eff, `CAR_REG_REG, `CAR_IND_REG0, `CAR_IDX_REG0);
        end else if (jmp) begin
            dec_state = S_JMP0;
        end else if (fmt2) begin
            case (IW_next[9:7])
                3'b100:  dec_state = by_as(as_raw, `CAR_PUSH_REG0, `CAR_PUSH_IND0, `CAR_PUSH_IDX0);
                3'b101:  dec_state = by_as(as_raw, `CAR_CALL_REG0, `CAR_CALL_IND0, `CAR_CALL_IDX0);
                3'b110:  dec_state = S_RETI0;
                3'b111:  dec_illegal = 1'b1;
                default: dec_state = by_as(as_raw, `CAR_1OP_REG, `CAR_1OP_IND0, `CAR_1OP_IDX0);
            endcase
        end else begin
            dec_illegal = 1'b1;
        end
    end

    // Last step of each instruction sequence; the only points where an interrupt may enter.
    always_comb begin
        is_term = 1'b0;
        case (car_q)
            CAR_BITS'(`CAR_REG_REG),   CAR_BITS'(`CAR_REG_IDX3),  CAR_BITS'(`CAR_IND_REG1),
            CAR_BITS'(`CAR_IND_IDX4),  CAR_BITS'(`CAR_IDX_REG2),  CAR_BITS'(`CAR_IDX_IDX5),
            CAR_BITS'(`CAR_1OP_REG),   CAR_BITS'(`CAR_1OP_IND2),  CAR_BITS'(`CAR_1OP_IDX3),
            CAR_BITS'(`CAR_PUSH_REG2), CAR_BITS'(`CAR_PUSH_IND2), CAR_BITS'(`CAR_PUSH_IDX3),
            CAR_BITS'(`CAR_CALL_REG2), CAR_BITS'(`CAR_CALL_IND2), CAR_BITS'(`CAR_CALL_IDX3),
            CAR_BITS'(`CAR_RETI3),     CAR_BITS'(`CAR_JMP0):  is_term = 1'b1;
            default: ;
        endcase
    end

    // Sequences are encoded contiguously, so a non-terminal step simply increments.
    always_comb begin
        car_d     = car_q;
        int_ack_d = 1'b0;
        illegal_d = 1'b0;
        if (ready) begin
            if (car_q == S_FETCH) begin
                car_d     = dec_state;
                illegal_d = dec_illegal;
            end else if ((car_q == S_INT4) || (car_q >= S_LIMIT)) begin
                car_d = S_FETCH;
            end else if (is_term) begin
                car_d = (int_req && gie) ? S_INT0 : S_FETCH;
            end else begin
                car_d = car_q + CAR_BITS'(1);
            end
            int_ack_d = (car_d == S_INT4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            car_q     <= S_FETCH;
            int_ack_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            car_q     <= car_d;
            int_ack_q <= int_ack_d;
            illegal_q <= illegal_d;
        end
    end

    assign CAR     = car_q;
    assign int_ack = int_ack_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_car_sequencer.sv
// Bench for car_sequencer: directed instruction scenarios, then random traffic
// compared against a sequence/step-level reference model.
module tb_car_sequencer;

    localparam int unsigned CAR_BITS = 6;
    localparam int K_FETCH  = 0;
    localparam int K_SEQ    = 1;
    localparam int K_INT    = 2;
    localparam int INT_BASE = 55;

    // Entry code and length of each sequence: index = mode*2 + Ad (mode 0 reg, 1 ind, 2 idx).
    localparam int F1_BASE [0:5] = '{1, 2, 6, 8, 13, 16};
    localparam int F1_LEN  [0:5] = '{1, 4, 2, 5, 3, 6};
    // Index = class*3 + mode (class 0 single-op, 1 PUSH, 2 CALL).
    localparam int F2_BASE [0:8] = '{22, 23, 26, 30, 33, 36, 40, 43, 46};
    localparam int F2_LEN  [0:8] = '{1, 3, 4, 3, 3, 4, 3, 3, 4};

    logic                clk;
    logic                rst;
    logic [15:0]         IW_next;
    logic                ready;
    logic                int_req;
    logic                gie;
    logic [CAR_BITS-1:0] CAR;
    logic                int_ack;
    logic                illegal;

    int   checks = 0;
    int   errors = 0;
    int   m_kind, m_base, m_len, m_step;
    logic m_ack, m_ill;

    car_sequencer #(.CAR_BITS(CAR_BITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .IW_next(IW_next),
        .ready  (ready),
        .int_req(int_req),
        .gie    (gie),
        .CAR    (CAR),
        .int_ack(int_ack),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void decode(input logic [15:0] iw, output int base, output int len,
                                   output bit ill);
        int src, as_m, ad, mode, op, cls;
        base = 0; len = 0; ill = 1'b0;
        src  = int'(iw[11:8]);
        as_m = int'(iw[5:4]);
        ad   = int'(iw[7]);
        mode = (as_m == 0) ? 0 : ((as_m >= 2) ? 1 : 2);
        if (iw >= 16'h4000) begin
            if (src == 3 || (src == 2 && as_m >= 2)) mode = 0;
            base = F1_BASE[mode*2 + ad];
            len  = F1_LEN[mode*2 + ad];
        end else if (iw >= 16'h2000) begin
            base = 54; len = 1;
        end else if (iw >= 16'h1000 && iw < 16'h1400) begin
            op = int'(iw[9:7]);
            if (op == 6) begin
                base = 50; len = 4;
            end else if (op == 7) begin
                ill = 1'b1;
            end else begin
                cls  = (op < 4) ? 0 : op - 3;
                base = F2_BASE[cls*3 + mode];
                len  = F2_LEN[cls*3 + mode];
            end
        end else begin
            ill = 1'b1;
        end
    endfunction

    function automatic int exp_car();
        if (m_kind == K_SEQ) return m_base + m_step;
        if (m_kind == K_INT) return INT_BASE + m_step;
        return 0;
    endfunction

    task automatic model_reset();
        m_kind = K_FETCH; m_base = 0; m_len = 0; m_step = 0;
        m_ack = 1'b0; m_ill = 1'b0;
    endtask

    task automatic model_edge(input logic [15:0] iw, input logic rdy, input logic irq,
                              input logic g);
        int b, l;
        bit ill;
        m_ack = 1'b0;
        m_ill = 1'b0;
        if (!rdy) return;
        case (m_kind)
            K_FETCH: begin
                decode(iw, b, l, ill);
                if (ill) m_ill = 1'b1;
                else begin
                    m_kind = K_SEQ; m_base = b; m_len = l; m_step = 0;
                end
            end
            K_SEQ: begin
                if (m_step < m_len - 1) m_step++;
                else if (irq && g) begin
                    m_kind = K_INT; m_step = 0;
                end else m_kind = K_FETCH;
            end
            default: begin
                if (m_step < 4) begin
                    m_step++;
                    m_ack = (m_step == 4);
                end else m_kind = K_FETCH;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " CAR"},     8'(CAR),     8'(exp_car()));
        chk({tag, " int_ack"}, 8'(int_ack), 8'(m_ack));
        chk({tag, " illegal"}, 8'(illegal), 8'(m_ill));
    endtask

    task automatic cycle(input logic [15:0] iw, input logic rdy, input logic irq, input logic g,
                         input string tag);
        IW_next = iw; ready = rdy; int_req = irq; gie = g;
        @(posedge clk);
        model_edge(iw, rdy, irq, g);
        #1 check_all(tag);
    endtask

    // Asynchronous reset between edges, held across one ready edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all({tag, " async"});
        IW_next = 16'h4506; ready = 1'b1;
        @(posedge clk);
        #1 check_all({tag, " held"});
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; ready = 1'b0; int_req = 1'b0; gie = 1'b0; IW_next = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        cycle(16'h4506, 1'b0, 1'b0, 1'b0, "post_rst_stall");
        cycle(16'h4506, 1'b1, 1'b0, 1'b0, "mov_fetch");
        cycle(16'h4506, 1'b1, 1'b0, 1'b0, "mov_done");

        cycle(16'h55B6, 1'b1, 1'b0, 1'b0, "add_fetch");
        cycle(16'h0000, 1'b1, 1'b0, 1'b0, "add_idx1");
        repeat (3) cycle(16'h0000, 1'b0, 1'b1, 1'b1, "add_stall");
        repeat (3) cycle(16'h0000, 1'b1, 1'b0, 1'b0, "add_run");
        cycle(16'h0000, 1'b1, 1'b0, 1'b0, "add_end");

        cycle(16'h4325, 1'b1, 1'b0, 1'b0, "cg_fetch");
        cycle(16'h4325, 1'b1, 1'b0, 1'b0, "cg_done");

        cycle(16'h1205, 1'b1, 1'b0, 1'b0, "push_fetch");
        repeat (3) cycle(16'h1205, 1'b1, 1'b0, 1'b0, "push_run");
        cycle(16'h1300, 1'b1, 1'b0, 1'b0, "reti_fetch");
        repeat (4) cycle(16'h1300, 1'b1, 1'b0, 1'b0, "reti_run");

        cycle(16'h3C00, 1'b1, 1'b1, 1'b1, "jmp_int_fetch");
        cycle(16'h3C00, 1'b1, 1'b1, 1'b1, "jmp_int_take");
        repeat (4) cycle(16'h3C00, 1'b1, 1'b0, 1'b0, "int_run");
        cycle(16'h3C00, 1'b1, 1'b0, 1'b0, "int_end");
        cycle(16'h3C00, 1'b1, 1'b1, 1'b0, "jmp_nogie_fetch");
        cycle(16'h3C00, 1'b1, 1'b1, 1'b0, "jmp_nogie_done");

        cycle(16'h0000, 1'b1, 1'b0, 1'b0, "ill_zero");
        cycle(16'h1380, 1'b1, 1'b0, 1'b0, "ill_1380");
        cycle(16'h1380, 1'b0, 1'b0, 1'b0, "ill_stall");

        cycle(16'h4596, 1'b1, 1'b0, 1'b0, "idxidx_fetch");
        repeat (2) cycle(16'h4596, 1'b1, 1'b0, 1'b0, "idxidx_run");
        do_reset("rst_mid");
        cycle(16'h4506, 1'b1, 1'b0, 1'b0, "after_rst");

        for (int n = 0; n < 600; n++) begin
            logic [15:0] iw;
            if ($urandom_range(0, 3) == 0) iw = {6'b000100, 10'($urandom)};
            else                           iw = 16'($urandom);
            if ($urandom_range(0, 99) == 0)
                do_reset("rand_rst");
            else
                cycle(iw, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
